// File: rtl/tile_scratchpad.sv
// Single-port 128-bit tile memory shared by the accelerator and a 32-bit host.
// Define SPAD_PERF_CNT_EN to build the access/stall performance counters.
module tile_scratchpad #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          interface_en,
    input  logic          interface_rdwr,
    input  logic [AW-1:0] interface_addr,
    input  logic [4:0]    interface_control,
    input  logic [127:0]  interface_wr_data,
    output logic [127:0]  interface_rd_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    input  logic [3:0]    host_be,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [31:0]   host_rdata,
    output logic          oob_err,
    output logic [31:0]   perf_acc_cnt,
    output logic [31:0]   perf_host_stall_cnt
);

    localparam int IW = $clog2(DEPTH);

    logic [127:0]  mem [DEPTH];
    logic          acc_go;
    logic          acc_ok;
    logic          host_ok;
    logic          gnt;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic [15:0]   acc_mask;
    logic [15:0]   wmask;
    logic [127:0]  wdata;
    logic [127:0]  rword;
    logic          we;
    logic          rvalid_q;
    logic          unused_addr;

    assign unused_addr = ^{interface_addr[3:0], host_addr[1:0]};

    assign acc_go  = interface_en && !rst;
    assign acc_ok  = ~|interface_addr[AW-1:4+IW];
    assign host_ok = ~|host_addr[AW-1:4+IW];
    assign gnt     = host_req && !interface_en && !rst;
    assign lane    = host_addr[3:2];

    assign host_gnt    = gnt;
    assign host_rvalid = rvalid_q && !rst;

    always_comb begin
        if (interface_control == 5'd0 || interface_control >= 5'd16)
            acc_mask = 16'hFFFF;
        else
            acc_mask = (16'd1 << interface_control) - 16'd1;
    end

    // One shared array port: accelerator has priority over the host.
    always_comb begin
        idx   = host_addr[4+:IW];
        we    = 1'b0;
        wmask = '0;
        wdata = {4{host_wdata}};
        unique case (1'b1)
            acc_go: begin
                idx   = interface_addr[4+:IW];
                we    = interface_rdwr && acc_ok;
                wmask = acc_mask;
                wdata = interface_wr_data;
            end
            gnt: begin
                we    = host_we && host_ok;
                wmask = 16'(host_be) << {lane, 2'b00};
            end
            default: ;
        endcase
    end

    assign rword = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 16; i++) begin
                if (wmask[i])
                    mem[idx][8*i+:8] <= wdata[8*i+:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            interface_rd_data <= '0;
            host_rdata        <= '0;
            rvalid_q          <= 1'b0;
            oob_err           <= 1'b0;
        end else begin
            rvalid_q <= gnt && !host_we;
            if (acc_go && !interface_rdwr)
                interface_rd_data <= acc_ok ? rword : '0;
            if (gnt && !host_we)
                host_rdata <= host_ok ? rword[{lane, 5'b0}+:32] : '0;
            if ((acc_go && !acc_ok) || (gnt && !host_ok))
                oob_err <= 1'b1;
        end
    end

`ifdef SPAD_PERF_CNT_EN
    logic [31:0] acc_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (interface_en && acc_cnt != '1)
                acc_cnt <= acc_cnt + 32'd1;
            if (host_req && !gnt && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_acc_cnt        = acc_cnt;
    assign perf_host_stall_cnt = stall_cnt;
`else
    assign perf_acc_cnt        = '0;
    assign perf_host_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tile_scratchpad.sv
// Directed bench for tile_scratchpad: host/accelerator access, arbitration,
// byte masking, out-of-range handling and mid-operation reset.
module tb_tile_scratchpad;

    logic         clk = 1'b0;
    logic         rst;
    logic         interface_en;
    logic         interface_rdwr;
    logic [31:0]  interface_addr;
    logic [4:0]   interface_control;
    logic [127:0] interface_wr_data;
    logic [127:0] interface_rd_data;
    logic         host_req;
    logic         host_we;
    logic [31:0]  host_addr;
    logic [31:0]  host_wdata;
    logic [3:0]   host_be;
    logic         host_gnt;
    logic         host_rvalid;
    logic [31:0]  host_rdata;
    logic         oob_err;
    logic [31:0]  perf_acc_cnt;
    logic [31:0]  perf_host_stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;

    tile_scratchpad #(.DEPTH(1024), .AW(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .interface_en        (interface_en),
        .interface_rdwr      (interface_rdwr),
        .interface_addr      (interface_addr),
        .interface_control   (interface_control),
        .interface_wr_data   (interface_wr_data),
        .interface_rd_data   (interface_rd_data),
        .host_req            (host_req),
        .host_we             (host_we),
        .host_addr           (host_addr),
        .host_wdata          (host_wdata),
        .host_be             (host_be),
        .host_gnt            (host_gnt),
        .host_rvalid         (host_rvalid),
        .host_rdata          (host_rdata),
        .oob_err             (oob_err),
        .perf_acc_cnt        (perf_acc_cnt),
        .perf_host_stall_cnt (perf_host_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one host request at a negedge; returns at the following negedge.
    task automatic host_op(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        host_req   = 1'b1;
        host_we    = w;
        host_addr  = a;
        host_wdata = d;
        host_be    = be;
        #1 chk("host_gnt", 128'(host_gnt), 128'(1'b1));
        @(negedge clk);
        host_req = 1'b0;
    endtask

    task automatic acc_op(input logic w, input logic [31:0] a,
                          input logic [4:0] ctl, input logic [127:0] d);
        interface_en      = 1'b1;
        interface_rdwr    = w;
        interface_addr    = a;
        interface_control = ctl;
        interface_wr_data = d;
        n_acc++;
        @(negedge clk);
        interface_en = 1'b0;
    endtask

    task automatic chk_perf(input int stall);
`ifdef SPAD_PERF_CNT_EN
        chk("perf_acc", 128'(perf_acc_cnt), 128'(n_acc));
        chk("perf_stall", 128'(perf_host_stall_cnt), 128'(stall));
`else
        chk("perf_acc", 128'(perf_acc_cnt), 128'(0));
        chk("perf_stall", 128'(perf_host_stall_cnt), 128'(0 * stall));
`endif
    endtask

    initial begin
        rst = 1'b1;
        interface_en = 0; interface_rdwr = 0; interface_addr = 0;
        interface_control = 0; interface_wr_data = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        host_be = 0;
        repeat (2) @(negedge clk);

        // Reset state, with a host write held through reset
        host_req = 1; host_we = 1; host_addr = 32'h10;
        host_wdata = 32'hDEADBEEF; host_be = 4'hF;
        #1;
        chk("rst_gnt", 128'(host_gnt), 128'(0));
        chk("rst_rd_data", interface_rd_data, 128'h0);
        chk("rst_rvalid", 128'(host_rvalid), 128'(0));
        chk("rst_rdata", 128'(host_rdata), 128'(0));
        chk("rst_oob", 128'(oob_err), 128'(0));
        chk_perf(0);
        @(negedge clk);
        rst = 1'b0;
        // Held write is granted in the first cycle after reset
        #1 chk("gnt_after_rst", 128'(host_gnt), 128'(1));
        @(negedge clk);
        host_req = 0;
        host_op(1'b0, 32'h10, 32'h0, 4'hF);
        chk("rvalid_10", 128'(host_rvalid), 128'(1));
        chk("rdata_10", 128'(host_rdata), 128'hDEADBEEF);
        @(negedge clk);
        chk("rvalid_drop", 128'(host_rvalid), 128'(0));
        chk("rdata_hold", 128'(host_rdata), 128'hDEADBEEF);

        // Host fills lanes of word 0x20, accelerator reads it back
        host_op(1'b1, 32'h20, 32'd1, 4'hF);
        host_op(1'b1, 32'h24, 32'd2, 4'hF);
        host_op(1'b1, 32'h28, 32'd3, 4'hF);
        host_op(1'b1, 32'h2C, 32'd4, 4'hF);
        chk("no_rvalid_wr", 128'(host_rvalid), 128'(0));
        acc_op(1'b0, 32'h20, 5'd0, 128'h0);
        chk("acc_rd_20", interface_rd_data,
            128'h00000004_00000003_00000002_00000001);

        // Accelerator byte-count masking
        acc_op(1'b1, 32'h30, 5'd0, {128{1'b1}});
        acc_op(1'b1, 32'h30, 5'd4, 128'h0);
        acc_op(1'b0, 32'h30, 5'd0, 128'h0);
        chk("acc_rd_30", interface_rd_data,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
        acc_op(1'b1, 32'h40, 5'd20,
               128'h01234567_89ABCDEF_FEDCBA98_76543210);
        acc_op(1'b0, 32'h4C, 5'd0, 128'h0);
        chk("acc_rd_40", interface_rd_data,
            128'h01234567_89ABCDEF_FEDCBA98_76543210);
        host_op(1'b0, 32'h34, 32'h0, 4'h0);
        chk("host_rd_34", 128'(host_rdata), 128'hFFFFFFFF);
        host_op(1'b0, 32'h30, 32'h0, 4'h0);
        chk("host_rd_30", 128'(host_rdata), 128'h0);

        // Host partial byte-enable merge
        host_op(1'b1, 32'h20, 32'hAABBCCDD, 4'b0010);
        host_op(1'b0, 32'h20, 32'h0, 4'h0);
        chk("host_be_merge", 128'(host_rdata), 128'h0000CC01);

        // Host blocked for 5 accelerator cycles
        host_req = 1; host_we = 0; host_addr = 32'h10; host_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            interface_en = 1; interface_rdwr = 0; interface_addr = 32'h30;
            n_acc++;
            #1 chk("stall_gnt", 128'(host_gnt), 128'(0));
            @(negedge clk);
        end
        interface_en = 0;
        #1 chk("stall_release", 128'(host_gnt), 128'(1));
        chk_perf(5);
        @(negedge clk);
        host_req = 0;
        chk("stall_rdata", 128'(host_rdata), 128'hDEADBEEF);

        // Out-of-range accelerator read
        chk("oob_before", 128'(oob_err), 128'(0));
        acc_op(1'b0, 32'h4000, 5'd0, 128'h0);
        chk("oob_rd_data", interface_rd_data, 128'h0);
        chk("oob_set", 128'(oob_err), 128'(1));
        repeat (3) @(negedge clk);
        chk("oob_sticky", 128'(oob_err), 128'(1));

        // Reset the cycle after a granted host read
        host_op(1'b0, 32'h10, 32'h0, 4'h0);
        rst = 1'b1;
        #1 chk("rst_cancel_rvalid", 128'(host_rvalid), 128'(0));
        @(negedge clk);
        chk("rst2_rvalid", 128'(host_rvalid), 128'(0));
        chk("rst2_rdata", 128'(host_rdata), 128'(0));
        chk("rst2_rd_data", interface_rd_data, 128'h0);
        chk("rst2_oob", 128'(oob_err), 128'(0));
        chk("rst2_gnt", 128'(host_gnt), 128'(0));
        n_acc = 0;
        chk_perf(0);
        rst = 1'b0;
        host_op(1'b0, 32'h10, 32'h0, 4'h0);
        chk("kept_rvalid", 128'(host_rvalid), 128'(1));
        chk("kept_host", 128'(host_rdata), 128'hDEADBEEF);
        acc_op(1'b0, 32'h20, 5'd0, 128'h0);
        chk("kept_acc", interface_rd_data,
            128'h00000004_00000003_00000002_0000CC01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tile_scratchpad.md
Name: tile_scratchpad

Overview:
- Single-port, 128-bit-wide on-chip tile memory directly downstream of the accelerator top's memory interface.
- Serves the accelerator port (interface_*) with fixed 1-cycle read latency, with no stall.
- Serves a 32-bit host port (CPU loads operand tiles, reads result tiles) with a req/gnt handshake.
- Host is arbitrated at lower priority than the accelerator.

Parameters:
DEPTH, 1024, number of 128-bit words; must be a power of two
AW, 32, byte-address width of both ports

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
interface_en  in  1  accelerator access valid this cycle
interface_rdwr  in  1  1 = write, 0 = read
interface_addr  in  AW  byte address; bits [3:0] ignored
interface_control  in  5  write byte count: 0 or >=16 means all 16 bytes, else lanes [n-1:0]
interface_wr_data  in  128  accelerator write data
interface_rd_data  out  128  accelerator read data
host_req  in  1  host request, held until granted
host_we  in  1  1 = write
host_addr  in  AW  byte address; bits [1:0] ignored
host_wdata  in  32  host write data
host_be  in  4  host byte enables
host_gnt  out  1  request accepted this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  32  host read data
oob_err  out  1  sticky out-of-range access flag
perf_acc_cnt  out  32  accelerator access count (optional feature)
perf_host_stall_cnt  out  32  host stall-cycle count (optional feature)

Behaviour:
- Reset values: interface_rd_data=0, host_gnt=0, host_rvalid=0, host_rdata=0, oob_err=0, counters=0. Memory contents are not reset.
- Word index: accelerator uses addr[AW-1:4]; host uses addr[AW-1:4], with lane = addr[3:2].
- In range: word index < DEPTH.
- Out-of-range reads return 0, out-of-range writes are dropped, and oob_err sets. oob_err clears only on rst.
- Arbitration each cycle:
  - If interface_en, the accelerator owns the array and host_gnt=0.
  - Else if host_req, host_gnt=1 (combinational, same cycle) and the host access executes.
- Accelerator read: interface_rd_data is registered and updated the cycle after the en/read cycle. It holds its last value otherwise.
- Accelerator write:
  - Byte mask = (control==0 || control>=16) ? 16'hFFFF : (1<<control)-1.
  - Lane i carries bits [8i+7:8i].
- Host write: merges host_wdata into 32-bit lane addr[3:2] under host_be; other lanes are untouched.
- Host read:
  - host_rvalid pulses one cycle after a granted read, with host_rdata = selected lane.
  - host_rdata holds between pulses.
  - No rvalid is issued for writes.
- Read-after-write (write in cycle N, read of same word in cycle N+1) returns the new data.
- Host requests wait indefinitely while the accelerator is busy. The host must keep req/addr/we/wdata/be stable until gnt.
- Reset mid-operation: any in-flight host_rvalid is cancelled. A request held through reset is granted no earlier than the first cycle after rst deasserts.
- host_gnt is never asserted while rst is high.

Optional Feature:
- Macro: SPAD_PERF_CNT_EN.
- When defined:
  - perf_acc_cnt increments on every interface_en cycle.
  - perf_host_stall_cnt increments on every cycle with host_req && !host_gnt.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Host writes 32'hDEADBEEF to 0x10 (be=4'hF) then reads 0x10 -> gnt same cycle, rvalid one cycle later, host_rdata=32'hDEADBEEF.
- Host fills word 0x20 lanes with 1,2,3,4; accelerator reads 0x20 -> next cycle interface_rd_data=128'h00000004_00000003_00000002_00000001.
- Accelerator writes all-ones to 0x30 with control=0, then 128'h0 with control=4, then reads -> 128'hFFFF..FF_00000000 (low 4 bytes cleared).
- Host holds req while interface_en is high for 5 cycles -> host_gnt=0 for 5 cycles, asserts on the 6th, perf_host_stall_cnt=5 with SPAD_PERF_CNT_EN.
- Accelerator read at byte address DEPTH*16 -> interface_rd_data=0 next cycle, oob_err=1 and stays 1 until rst.
- Assert rst in the cycle after a granted host read -> host_rvalid stays 0, all outputs return to reset values, memory data is preserved on a later read.
